// File: rtl/sccb_responder_if.sv
// sccb_responder_if
//   Two-wire SCCB bus bundle between an initiator and the sccb_responder.
//   scl    : bus clock driven by the initiator
//   sda_i  : sda as seen on the pad (wired-AND of every open-drain driver)
//   sda_oe : responder pull-down enable, 1 = pull sda low
//   modport master : initiator side (drives scl/pad view, observes sda_oe)
//   modport slave  : responder side
interface sccb_responder_if;
  logic scl;
  logic sda_i;
  logic sda_oe;

  modport master (output scl, output sda_i, input sda_oe);
  modport slave  (input scl, input sda_i, output sda_oe);
endinterface

// File: rtl/sccb_responder.sv
// sccb_responder
//   SCCB/I2C target holding a byte register file that an on-board initiator
//   can write and read back in loopback. Each bus write is also reported on a
//   host-side strobe, and the FSM state is exported for a 7-segment digit.
//   clk       : system clock, at least 8x the scl rate
//   rst       : synchronous reset, active low
//   bus       : scl / sda_i / sda_oe (open drain, never drives a 1)
//   wr_stb    : one-cycle pulse per bus data byte written
//   wr_addr   : register index of that write
//   wr_data   : byte of that write
//   host_addr : host read index
//   host_data : reg[host_addr], registered, 1-cycle latency
//   busy      : state != IDLE
//   sta       : state encoding
//   ADDR_BITS must not exceed 8 (the sub-address is a single bus byte).
//
//   state | meaning
//   IDLE  | wait for START
//   DEVA  | shift in device address + rw bit
//   ACK1  | ACK the device address, then branch on rw
//   SUBA  | shift in register sub-address into ptr
//   ACK2  | ACK the sub-address
//   WDAT  | shift in a data byte, write reg[ptr], ptr++
//   ACK3  | ACK the data byte, loop back to WDAT
//   RDAT  | shift reg[ptr] out MSB first, ptr++
//   RACK  | sample the initiator's ACK/NACK
//   IGNR  | not addressed / read ended, stay released until START/STOP
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h21,
  parameter int         ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sccb_responder_if.slave      bus,
  output logic                 wr_stb,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  input  logic [ADDR_BITS-1:0] host_addr,
  output logic [7:0]           host_data,
  output logic                 busy,
  output logic [3:0]           sta
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    DEVA = 4'd1,
    ACK1 = 4'd2,
    SUBA = 4'd3,
    ACK2 = 4'd4,
    WDAT = 4'd5,
    ACK3 = 4'd6,
    RDAT = 4'd7,
    RACK = 4'd8,
    IGNR = 4'd9
  } state_t;

  state_t               state, state_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [7:0]           sh, sh_n;
  logic                 rw, rw_n;
  logic [ADDR_BITS-1:0] ptr, ptr_n;
  logic                 oe, oe_n;
  logic                 stb_n;
  logic [ADDR_BITS-1:0] waddr_n;
  logic [7:0]           wdata_n;
  logic                 mem_we;
  logic [7:0]           byte_in;
  logic [7:0]           mem_rd;
  logic                 last_bit;

  logic [7:0] mem [DEPTH];

  // Pad synchronisers are left out of reset so they keep tracking the pins;
  // an edge seen right after reset can at worst look like a STOP in IDLE.
  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  always_ff @(posedge clk) begin
    scl_meta <= bus.scl;
    scl_sync <= scl_meta;
    scl_prev <= scl_sync;
    sda_meta <= bus.sda_i;
    sda_sync <= sda_meta;
    sda_prev <= sda_sync;
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_sync & ~scl_prev;
  assign scl_fall = ~scl_sync & scl_prev;
  // scl must be high on both samples so a data change racing an scl edge is
  // not mistaken for a bus condition.
  assign start_c  = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_c   = scl_sync & scl_prev & ~sda_prev & sda_sync;

  assign byte_in  = {sh[6:0], sda_sync};
  assign last_bit = (bit_cnt == 3'd7);
  assign mem_rd   = mem[ptr];

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sh_n    = sh;
    rw_n    = rw;
    ptr_n   = ptr;
    oe_n    = oe;
    stb_n   = 1'b0;
    waddr_n = wr_addr;
    wdata_n = wr_data;
    mem_we  = 1'b0;

    if (start_c) begin
      state_n = DEVA;
      bit_n   = 3'd0;
      oe_n    = 1'b0;
    end else if (stop_c) begin
      state_n = IDLE;
      bit_n   = 3'd0;
      oe_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: oe_n = 1'b0;

        DEVA: if (scl_rise) begin
          sh_n  = byte_in;
          bit_n = bit_cnt + 3'd1;
          if (last_bit) begin
            bit_n = 3'd0;
            if (byte_in[7:1] == DEV_ADDR) begin
              rw_n    = byte_in[0];
              state_n = ACK1;
            end else begin
              state_n = IGNR;
            end
          end
        end

        // ACK states: bit_cnt 0 waits for the 8th-bit fall and pulls sda,
        // bit_cnt 1 waits for the 9th-bit fall and moves on.
        ACK1: if (scl_fall) begin
          if (bit_cnt == 3'd0) begin
            oe_n  = 1'b1;
            bit_n = 3'd1;
          end else begin
            bit_n = 3'd0;
            if (rw) begin
              sh_n    = mem_rd;
              oe_n    = ~mem_rd[7];
              state_n = RDAT;
            end else begin
              oe_n    = 1'b0;
              state_n = SUBA;
            end
          end
        end

        SUBA: if (scl_rise) begin
          sh_n  = byte_in;
          bit_n = bit_cnt + 3'd1;
          if (last_bit) begin
            bit_n   = 3'd0;
            ptr_n   = byte_in[ADDR_BITS-1:0];
            state_n = ACK2;
          end
        end

        ACK2, ACK3: if (scl_fall) begin
          if (bit_cnt == 3'd0) begin
            oe_n  = 1'b1;
            bit_n = 3'd1;
          end else begin
            oe_n    = 1'b0;
            bit_n   = 3'd0;
            state_n = WDAT;
          end
        end

        WDAT: if (scl_rise) begin
          sh_n  = byte_in;
          bit_n = bit_cnt + 3'd1;
          if (last_bit) begin
            bit_n   = 3'd0;
            mem_we  = 1'b1;
            stb_n   = 1'b1;
            waddr_n = ptr;
            wdata_n = byte_in;
            ptr_n   = ptr + ADDR_BITS'(1);
            state_n = ACK3;
          end
        end

        // MSB is already on the wire at entry; each fall moves to the next
        // bit by rotating sh, and the 8th fall releases sda for the ACK slot.
        RDAT: if (scl_fall) begin
          if (last_bit) begin
            oe_n    = 1'b0;
            bit_n   = 3'd0;
            ptr_n   = ptr + ADDR_BITS'(1);
            state_n = RACK;
          end else begin
            bit_n = bit_cnt + 3'd1;
            sh_n  = {sh[6:0], sh[7]};
            oe_n  = ~sh[6];
          end
        end

        // An ACK is sampled on the rise but the next byte may only be put on
        // sda after the following fall.
        RACK: begin
          if (scl_rise && bit_cnt == 3'd0) begin
            if (sda_sync) begin
              state_n = IGNR;
            end else begin
              bit_n = 3'd1;
            end
          end else if (scl_fall && bit_cnt == 3'd1) begin
            bit_n   = 3'd0;
            sh_n    = mem_rd;
            oe_n    = ~mem_rd[7];
            state_n = RDAT;
          end
        end

        IGNR: oe_n = 1'b0;

        default: begin
          state_n = IDLE;
          bit_n   = 3'd0;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      sh        <= 8'd0;
      rw        <= 1'b0;
      ptr       <= '0;
      oe        <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      host_data <= 8'd0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      sh        <= sh_n;
      rw        <= rw_n;
      ptr       <= ptr_n;
      oe        <= oe_n;
      wr_stb    <= stb_n;
      wr_addr   <= waddr_n;
      wr_data   <= wdata_n;
      host_data <= mem[host_addr];
    end
  end

  // Register file is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[ptr] <= byte_in;
  end

  assign bus.sda_oe = oe;
  assign busy       = (state != IDLE);
  assign sta        = state;

endmodule

// File: tb/tb_sccb_responder.sv
module tb_sccb_responder;

  localparam int Q = 8;  // clk cycles per quarter scl bit

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data;
  logic [7:0] host_addr, host_data;
  logic       busy;
  logic [3:0] sta;

  sccb_responder_if bus();
  assign bus.scl   = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  sccb_responder #(.DEV_ADDR(7'h21), .ADDR_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .host_addr (host_addr),
    .host_data (host_data),
    .busy      (busy),
    .sta       (sta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wr_exp_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] model [256];
  logic [7:0] ptr_m;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         wr_seen = 0;
  int         wr_pushed = 0;
  logic       oe_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // write-strobe scoreboard
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (wr_stb) begin
      wr_seen++;
      if (wr_exp_q.size() != 0) begin
        e = wr_exp_q.pop_front();
        check_eq("wr_addr", wr_addr, e.addr);
        check_eq("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
    end
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = bus.sda_i; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b[i] = bus.sda_i; wait_q();
      scl_m = 1'b0; wait_q();
    end
    sda_m = nack; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
    sda_m = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] sub, input int n, input logic [7:0] d [4]);
    logic ack;
    wr_t  e;
    bus_start();
    write_byte(8'h42, ack); check_eq("ack_wdev", ack, 1'b0);
    write_byte(sub, ack);   check_eq("ack_sub", ack, 1'b0);
    ptr_m = sub;
    for (int i = 0; i < n; i++) begin
      e.addr = ptr_m;
      e.data = d[i];
      wr_exp_q.push_back(e);
      wr_pushed++;
      model[ptr_m] = d[i];
      write_byte(d[i], ack); check_eq("ack_data", ack, 1'b0);
      ptr_m = ptr_m + 8'd1;
    end
    bus_stop();
    check_eq("wr_count", wr_seen, wr_pushed);
    check_eq("queue_empty", wr_exp_q.size(), 0);
  endtask

  task automatic bus_read_byte(input logic nack);
    logic [7:0] got;
    rd_exp_q.push_back(model[ptr_m]);
    read_byte(nack, got);
    check_eq("rd_byte", got, rd_exp_q.pop_front());
    ptr_m = ptr_m + 8'd1;
  endtask

  task automatic host_check(input logic [7:0] a);
    host_addr = a;
    @(negedge clk);
    check_eq("host_data", host_data, model[a]);
  endtask

  initial begin
    logic ack;
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; host_addr = 8'h00; ptr_m = 8'h00;
    repeat (5) @(negedge clk);
    check_eq("rst_sda_oe", bus.sda_oe, 1'b0);
    check_eq("rst_wr_stb", wr_stb, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 8'h00);
    check_eq("rst_wr_data", wr_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sta", sta, 4'd0);
    check_eq("rst_host_data", host_data, 8'h00);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 1: single write
    bus_write(8'h12, 1, '{8'h80, 8'h00, 8'h00, 8'h00});
    check_eq("idle_sta", sta, 4'd0);
    host_check(8'h12);

    // 2: preload, set pointer, read one byte with NACK
    bus_write(8'h0A, 1, '{8'h5C, 8'h00, 8'h00, 8'h00});
    bus_write(8'h0A, 0, '{8'h00, 8'h00, 8'h00, 8'h00});
    bus_start();
    write_byte(8'h43, ack); check_eq("ack_rdev", ack, 1'b0);
    bus_read_byte(1'b1);
    check_eq("nack_released", bus.sda_oe, 1'b0);
    check_eq("nack_sta", sta, 4'd9);
    bus_stop();
    check_eq("stop_sta", sta, 4'd0);
    check_eq("stop_busy", busy, 1'b0);

    // 3: burst with pointer wrap
    bus_write(8'hFE, 3, '{8'h11, 8'h22, 8'h33, 8'h00});
    host_check(8'hFE);
    host_check(8'hFF);
    host_check(8'h00);

    // 4: wrong device id
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'h44, ack); check_eq("wrong_id_ack", ack, 1'b1);
    check_eq("wrong_id_sta", sta, 4'd9);
    write_byte(8'h12, ack); check_eq("wrong_id_ack2", ack, 1'b1);
    check_eq("wrong_id_sta2", sta, 4'd9);
    bus_stop();
    check_eq("wrong_id_oe", oe_seen, 1'b0);
    check_eq("wrong_id_wr", wr_seen, wr_pushed);
    check_eq("wrong_id_idle", sta, 4'd0);

    // 5: repeated start, ACK then NACK, pointer continues
    bus_write(8'h05, 3, '{8'hA1, 8'hB2, 8'hC3, 8'h00});
    bus_start();
    write_byte(8'h42, ack); check_eq("rs_ack_dev", ack, 1'b0);
    write_byte(8'h05, ack); check_eq("rs_ack_sub", ack, 1'b0);
    ptr_m = 8'h05;
    bus_start();
    write_byte(8'h43, ack); check_eq("rs_ack_rdev", ack, 1'b0);
    bus_read_byte(1'b0);
    bus_read_byte(1'b1);
    bus_stop();
    bus_start();
    write_byte(8'h43, ack); check_eq("ptr_ack_rdev", ack, 1'b0);
    bus_read_byte(1'b1);
    bus_stop();

    // 6: reset while a 0 bit is being driven
    bus_write(8'h20, 1, '{8'h0F, 8'h00, 8'h00, 8'h00});
    bus_start();
    write_byte(8'h42, ack); check_eq("r6_ack_dev", ack, 1'b0);
    write_byte(8'h20, ack); check_eq("r6_ack_sub", ack, 1'b0);
    bus_start();
    write_byte(8'h43, ack); check_eq("r6_ack_rdev", ack, 1'b0);
    check_eq("r6_driving", bus.sda_oe, 1'b1);
    check_eq("r6_sta_rdat", sta, 4'd7);
    rst = 1'b0;
    @(negedge clk);
    check_eq("r6_oe_reset", bus.sda_oe, 1'b0);
    check_eq("r6_sta_reset", sta, 4'd0);
    check_eq("r6_busy_reset", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    bus_write(8'h31, 1, '{8'h6B, 8'h00, 8'h00, 8'h00});
    host_check(8'h31);
    host_check(8'h12);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
